pdm_capture_seq: RTL and testbench
==================================

// Module: pdm_capture_seq
// PURPOSE
//  Sequencer for the pdm_m capture core on the AHB clock. Arms a capture, waits out bsy, then
//  streams the buffer as 32-bit words over valid/ready to a DMA/consumer, repeated cfg_frames times.
//  Replaces software polling of the status register; sits beside the AHB slave and owns pdm_m's ctrl/addr.
// PARAMETERS
//  BUF_BASE     32'h8000_0000  byte address of capture word 0; word i at BUF_BASE + 4*i
//  ARM_TIMEOUT  16             cycles allowed for bsy to rise after a start command
//  WORDS_W      10             width of the word count (max 1023 words per frame)
// PORTS
//  g_hclk_es1   in   1        AHB clock; all logic is on its rising edge
//  hreset_n     in   1        asynchronous active-low reset
//  cfg_start    in   1        1-cycle pulse: begin sequence (ignored unless IDLE)
//  cfg_abort    in   1        1-cycle pulse: stop sequence from any non-IDLE state
//  cfg_frames   in   8        frames per sequence, sampled at start; 0 is treated as 1
//  cfg_words    in   WORDS_W  words per frame, sampled at start; 0 means skip readout
//  pdm_ctrl     out  2        command to pdm_m: 00 nop, 01 start capture, 10 stop/clear
//  pdm_addr     out  32       read address to pdm_m
//  pdm_dout     in   32       pdm_m read data, valid 1 cycle after pdm_addr changes
//  pdm_bsy      in   1        pdm_m capture in progress
//  out_data     out  32       streamed sample word
//  out_valid    out  1        out_data valid
//  out_ready    in   1        consumer accepts when out_valid & out_ready
//  busy         out  1        high in every state except IDLE
//  done_irq     out  1        1-cycle pulse when the last word of the last frame is accepted
//  err_timeout  out  1        sticky; set when bsy fails to rise within ARM_TIMEOUT; cleared by cfg_start
// BEHAVIOUR
//  Reset values: pdm_ctrl=00, pdm_addr=BUF_BASE, out_data=0, out_valid=0, busy=0, done_irq=0,
//   err_timeout=0, state=IDLE. All outputs are registered.
//  States:
//   IDLE:  on cfg_start, latch frames/words, clear err_timeout, frame_cnt=0 -> ARM.
//   ARM:   pdm_ctrl=01 for exactly 1 cycle, tmo=0 -> WAIT_HI.
//   WAIT_HI: bsy=1 -> WAIT_LO. tmo reaches ARM_TIMEOUT-1 -> set err_timeout -> STOP.
//   WAIT_LO: bsy=0 -> word_cnt=0, pdm_addr=BUF_BASE -> FETCH. If words==0 -> FRAME_END.
//   FETCH: 1 wait cycle for pdm_dout -> PRESENT. On entry, latch pdm_dout into out_data; out_valid=1.
//   PRESENT: hold out_data/out_valid until out_ready. On accept: out_valid=0; if word_cnt==words-1
//    -> FRAME_END, else word_cnt++, pdm_addr+=4 -> FETCH.
//   FRAME_END: if frame_cnt==frames-1 -> done_irq=1 -> IDLE; else frame_cnt++ -> ARM.
//   STOP:  pdm_ctrl=10 for 1 cycle -> IDLE.
//  Throughput: 1 word per 2 cycles when out_ready is held high.
//  out_valid is never withdrawn and out_data never changes while out_valid=1 and out_ready=0.
//  cfg_abort: from any non-IDLE state -> STOP next cycle. out_valid drops and no done_irq pulses.
//   cfg_abort in IDLE is ignored. cfg_abort and cfg_start together in IDLE: start wins.
//  cfg_start while busy is ignored; changes to cfg_* while busy have no effect.
//  pdm_addr increments by 4 with 32-bit wrap; word_cnt stops at words-1 and never wraps.
//  bsy already high at ARM is allowed: WAIT_HI exits on the first cycle.
//  Reset asserted mid-sequence: immediately returns to reset values. No STOP command is issued.
// STRUCTURE
//  Shared package/include pdm_defs: PDM_CTRL_NOP/START/STOP encodings, state encodings,
//   BUF_BASE default.
//  One sub-module, pdm_seq_timeout: a loadable down-counter with an expiry flag, used in WAIT_HI.
//   The rest is a single FSM with its counters.
// TESTING
//  T1 frames=1, words=4, out_ready=1, bsy high 5 cycles after ARM:
//     ctrl=01 for 1 cycle; 4 words at addr BUF_BASE..+12; done_irq 1 cycle; busy falls.
//  T2 words=3, out_ready toggling 1/0:
//     out_data stable while stalled; exactly 3 beats; no duplicate or lost word.
//  T3 bsy never rises:
//     err_timeout sets after 16 cycles; ctrl=10 for 1 cycle; IDLE. Next cfg_start clears err_timeout.
//  T4 frames=3, words=2: ctrl=01 issued 3 times; 6 beats; 1 done_irq after beat 6.
//  T5 cfg_abort during PRESENT of word 1:
//     out_valid drops; ctrl=10; no done_irq. A fresh start begins at BUF_BASE.
//  T6 hreset_n low mid-WAIT_LO, then start with words=0, frames=2:
//     outputs at reset values; 2 ARM pulses; 0 beats; done_irq.

Source files
------------

// File: rtl/pdm_capture_seq_pkg.sv
// Shared definitions for the pdm_m capture sequencer: command encodings,
// sequencer states and default buffer geometry.
package pdm_capture_seq_pkg;

    localparam logic [31:0] PDM_BUF_BASE    = 32'h8000_0000;
    localparam int          PDM_ARM_TIMEOUT = 16;
    localparam int          PDM_WORDS_W     = 10;

    localparam logic [1:0] PDM_CTRL_NOP   = 2'b00;
    localparam logic [1:0] PDM_CTRL_START = 2'b01;
    localparam logic [1:0] PDM_CTRL_STOP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_HI   = 3'd2,
        ST_WAIT_LO   = 3'd3,
        ST_FETCH     = 3'd4,
        ST_PRESENT   = 3'd5,
        ST_FRAME_END = 3'd6,
        ST_STOP      = 3'd7
    } pdm_seq_state_t;

    // Capture buffer is word addressed in bytes and wraps at 32 bits.
    function automatic logic [31:0] pdm_next_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/pdm_capture_seq_timeout.sv
// Loadable down-counter with a registered expiry flag; bounds how long the
// sequencer waits for the capture core to report busy.
module pdm_seq_timeout #(
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic             r_expired;

    // Expiry is raised on the same edge the count reaches zero, so it is usable the following cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= CNT_ZERO;
            r_expired <= 1'b0;
        end else if (i_srst) begin
            r_cnt     <= CNT_ZERO;
            r_expired <= 1'b0;
        end else if (i_load) begin
            r_cnt     <= i_load_val;
            r_expired <= (i_load_val == CNT_ZERO);
        end else if (i_en && !r_expired) begin
            r_cnt     <= r_cnt - CNT_ONE;
            r_expired <= (r_cnt == CNT_ONE);
        end else begin
            r_cnt     <= r_cnt;
            r_expired <= r_expired;
        end
    end

    assign o_expired = r_expired;

endmodule

// File: rtl/pdm_capture_seq.sv
// Capture sequencer: arms pdm_m, waits out its busy pulse, then streams the
// capture buffer over valid/ready, repeated for the configured frame count.
module pdm_capture_seq
    import pdm_capture_seq_pkg::*;
#(
    parameter logic [31:0] BUF_BASE    = PDM_BUF_BASE,
    parameter int          ARM_TIMEOUT = PDM_ARM_TIMEOUT,
    parameter int          WORDS_W     = PDM_WORDS_W
) (
    input  logic               g_hclk_es1,
    input  logic               hreset_n,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [7:0]         cfg_frames,
    input  logic [WORDS_W-1:0] cfg_words,
    output logic [1:0]         pdm_ctrl,
    output logic [31:0]        pdm_addr,
    input  logic [31:0]        pdm_dout,
    input  logic               pdm_bsy,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done_irq,
    output logic               err_timeout
);

    localparam int                 TMO_W     = $clog2(ARM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(ARM_TIMEOUT - 1);
    localparam logic [WORDS_W-1:0] WORD_ZERO = {WORDS_W{1'b0}};
    localparam logic [WORDS_W-1:0] WORD_ONE  = {{(WORDS_W-1){1'b0}}, 1'b1};

    pdm_seq_state_t     r_state;
    logic [7:0]         r_frames_m1;
    logic [7:0]         r_frame_cnt;
    logic [WORDS_W-1:0] r_words;
    logic [WORDS_W-1:0] r_word_cnt;
    logic [1:0]         r_ctrl;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_abort;
    logic               w_tmo_load;
    logic               w_tmo_en;
    logic               w_tmo_expired;

    // STOP already returns to IDLE with a stop command, so an abort there has nothing left to do.
    assign w_abort    = cfg_abort && (r_state != ST_IDLE) && (r_state != ST_STOP);
    assign w_tmo_load = (r_state == ST_ARM);
    assign w_tmo_en   = (r_state == ST_WAIT_HI);

    pdm_seq_timeout #(
        .CNT_W(TMO_W)
    ) u_timeout (
        .i_clk      (g_hclk_es1),
        .i_rst_n    (hreset_n),
        .i_srst     (w_abort),
        .i_load     (w_tmo_load),
        .i_load_val (TMO_LOAD),
        .i_en       (w_tmo_en),
        .o_expired  (w_tmo_expired)
    );

    // Sequencer FSM; every output is set on the edge entering the state that owns it.
    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state     <= ST_IDLE;
            r_frames_m1 <= 8'd0;
            r_frame_cnt <= 8'd0;
            r_words     <= WORD_ZERO;
            r_word_cnt  <= WORD_ZERO;
            r_ctrl      <= PDM_CTRL_NOP;
            r_addr      <= BUF_BASE;
            r_data      <= 32'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ctrl <= PDM_CTRL_NOP;
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= ST_STOP;
                r_ctrl  <= PDM_CTRL_STOP;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cfg_start) begin
                            r_frames_m1 <= (cfg_frames == 8'd0) ? 8'd0 : (cfg_frames - 8'd1);
                            r_words     <= cfg_words;
                            r_frame_cnt <= 8'd0;
                            r_err       <= 1'b0;
                            r_busy      <= 1'b1;
                            r_ctrl      <= PDM_CTRL_START;
                            r_state     <= ST_ARM;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ARM: begin
                        r_state <= ST_WAIT_HI;
                    end
                    ST_WAIT_HI: begin
                        if (pdm_bsy) begin
                            r_state <= ST_WAIT_LO;
                        end else if (w_tmo_expired) begin
                            r_err   <= 1'b1;
                            r_ctrl  <= PDM_CTRL_STOP;
                            r_state <= ST_STOP;
                        end else begin
                            r_state <= ST_WAIT_HI;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (!pdm_bsy) begin
                            if (r_words == WORD_ZERO) begin
                                r_state <= ST_FRAME_END;
                            end else begin
                                r_word_cnt <= WORD_ZERO;
                                r_addr     <= BUF_BASE;
                                r_state    <= ST_FETCH;
                            end
                        end else begin
                            r_state <= ST_WAIT_LO;
                        end
                    end
                    ST_FETCH: begin
                        r_data  <= pdm_dout;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                    ST_PRESENT: begin
                        if (out_ready) begin
                            r_valid <= 1'b0;
                            if (r_word_cnt == (r_words - WORD_ONE)) begin
                                r_state <= ST_FRAME_END;
                            end else begin
                                r_word_cnt <= r_word_cnt + WORD_ONE;
                                r_addr     <= pdm_next_addr(r_addr);
                                r_state    <= ST_FETCH;
                            end
                        end else begin
                            r_state <= ST_PRESENT;
                        end
                    end
                    ST_FRAME_END: begin
                        if (r_frame_cnt == r_frames_m1) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_ctrl      <= PDM_CTRL_START;
                            r_state     <= ST_ARM;
                        end
                    end
                    ST_STOP: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pdm_ctrl    = r_ctrl;
    assign pdm_addr    = r_addr;
    assign out_data    = r_data;
    assign out_valid   = r_valid;
    assign busy        = r_busy;
    assign done_irq    = r_done;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_pdm_capture_seq.sv
// Randomized bench for pdm_capture_seq: a pdm_m responder, a consumer with
// selectable back-pressure, and a transaction-level model of the expected beats.
module tb_pdm_capture_seq;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        hreset_n;
    logic        cfg_start;
    logic        cfg_abort;
    logic [7:0]  cfg_frames;
    logic [9:0]  cfg_words;
    logic [1:0]  pdm_ctrl;
    logic [31:0] pdm_addr;
    logic [31:0] pdm_dout;
    logic        pdm_bsy;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done_irq;
    logic        err_timeout;

    typedef struct {
        logic [31:0] addr;
        int          idx;
    } exp_beat_t;

    exp_beat_t   exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_start, n_stop, n_done, n_beats, n_exp_total;
    int          cyc = 0, arm_cyc = 0, stop_cyc = 0, last_beat_cyc = 0;
    int          ready_mode = 0, bsy_delay = 1, bsy_len = 2;
    logic        bsy_never = 1'b0;
    logic [31:0] salt = 32'h0;

    pdm_capture_seq dut (
        .g_hclk_es1 (clk),
        .hreset_n   (hreset_n),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .cfg_frames (cfg_frames),
        .cfg_words  (cfg_words),
        .pdm_ctrl   (pdm_ctrl),
        .pdm_addr   (pdm_addr),
        .pdm_dout   (pdm_dout),
        .pdm_bsy    (pdm_bsy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done_irq   (done_irq),
        .err_timeout(err_timeout)
    );

    // Capture buffer contents as a function of address, reshuffled per run.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    assign pdm_dout = mem_word(pdm_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // pdm_m stand-in: after a start command, raise bsy after a delay and hold it a while.
    initial begin
        pdm_bsy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pdm_ctrl == 2'b01 && !bsy_never) begin
                for (int k = 0; k < bsy_delay; k++) begin @(posedge clk); #1; end
                pdm_bsy = 1'b1;
                for (int k = 0; k < bsy_len; k++) begin @(posedge clk); #1; end
                pdm_bsy = 1'b0;
            end
        end
    end

    // Consumer back-pressure: 0 always ready, 1 toggling, 2 random, else never ready.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: counts commands and pulses, checks each accepted beat and stall stability.
    initial begin
        logic        prev_valid, prev_ready, prev_abort;
        logic [31:0] prev_data;
        exp_beat_t   e;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_abort = 1'b0; prev_data = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pdm_ctrl == 2'b01) begin n_start++; arm_cyc = cyc; end
            if (pdm_ctrl == 2'b10) begin n_stop++; stop_cyc = cyc; end
            if (done_irq) begin
                n_done++;
                check_val("done_after_last_beat", 32'(exp_q.size()), 32'd0);
            end
            if (prev_valid && !prev_ready && !prev_abort && hreset_n) begin
                check_val("stall_valid_held", {31'd0, out_valid}, 32'd1);
                check_val("stall_data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 32'(n_beats), 32'(n_exp_total));
                end else begin
                    e = exp_q.pop_front();
                    check_val("beat_addr", pdm_addr, e.addr);
                    check_val("beat_data", out_data, mem_word(e.addr));
                    if (ready_mode == 0 && e.idx > 0)
                        check_val("beat_spacing", 32'(cyc - last_beat_cyc), 32'd2);
                end
                last_beat_cyc = cyc;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_abort = cfg_abort;
        end
    end

    task automatic clear_counts();
        exp_q.delete();
        n_exp_total = 0;
        n_start = 0; n_stop = 0; n_done = 0; n_beats = 0;
    endtask

    task automatic pulse_start(input int frames, input int words);
        @(posedge clk); #1;
        cfg_frames = 8'(frames);
        cfg_words  = 10'(words);
        cfg_start  = 1'b1;
        @(posedge clk); #1;
        cfg_start  = 1'b0;
        cfg_frames = 8'($urandom);
        cfg_words  = 10'($urandom);
    endtask

    task automatic run_seq(input int frames, input int words, input int rmode,
                           input int d, input int len, input logic tmo);
        int fe;
        fe = (frames == 0) ? 1 : frames;
        clear_counts();
        if (!tmo) begin
            for (int f = 0; f < fe; f++)
                for (int i = 0; i < words; i++) begin
                    exp_q.push_back('{addr: BASE + 32'(4 * i), idx: i});
                    n_exp_total++;
                end
        end
        ready_mode = rmode; bsy_delay = d; bsy_len = len; bsy_never = tmo;
        salt = $urandom;
        pulse_start(frames, words);
        @(negedge clk);
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
        check_val("arm_ctrl", {30'd0, pdm_ctrl}, 32'd1);
        check_val("err_cleared_on_start", {31'd0, err_timeout}, 32'd0);
        for (int k = 0; k < 4000 && busy; k++) @(negedge clk);
        check_val("busy_end", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check_val("arm_pulses", 32'(n_start), tmo ? 32'd1 : 32'(fe));
        check_val("stop_pulses", 32'(n_stop), tmo ? 32'd1 : 32'd0);
        check_val("done_pulses", 32'(n_done), tmo ? 32'd0 : 32'd1);
        check_val("beats_total", 32'(n_beats), 32'(n_exp_total));
        check_val("beats_missing", 32'(exp_q.size()), 32'd0);
        check_val("err_timeout", {31'd0, err_timeout}, {31'd0, tmo});
        if (tmo) check_val("timeout_cycles", 32'(stop_cyc - arm_cyc), 32'd17);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_ctrl"},  {30'd0, pdm_ctrl}, 32'd0);
        check_val({tag, "_addr"},  pdm_addr, BASE);
        check_val({tag, "_data"},  out_data, 32'd0);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_val({tag, "_done"},  {31'd0, done_irq}, 32'd0);
        check_val({tag, "_err"},   {31'd0, err_timeout}, 32'd0);
    endtask

    initial begin
        hreset_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_frames = 8'd0; cfg_words = 10'd0;
        clear_counts();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        hreset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, free-flowing consumer, bsy five cycles after arming.
        run_seq(1, 4, 0, 5, 3, 1'b0);
        // Toggling back-pressure.
        run_seq(1, 3, 1, 2, 4, 1'b0);
        // bsy never rises: timeout, stop, sticky error.
        run_seq(1, 4, 0, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        check_val("err_sticky_idle", {31'd0, err_timeout}, 32'd1);
        // Multi-frame; the start also clears the sticky error.
        run_seq(3, 2, 0, 1, 2, 1'b0);
        // frames=0 behaves as one frame; bsy already high at arm.
        run_seq(0, 1, 2, 0, 2, 1'b0);

        // Abort while a word is presented and stalled.
        clear_counts();
        ready_mode = 3; bsy_delay = 3; bsy_len = 3; bsy_never = 1'b0; salt = $urandom;
        pulse_start(1, 4);
        for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
        check_val("abort_word0_data", out_data, mem_word(BASE));
        check_val("abort_word0_addr", pdm_addr, BASE);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; cfg_abort = 1'b1;
        @(posedge clk); #1; cfg_abort = 1'b0;
        @(negedge clk);
        check_val("abort_valid_drop", {31'd0, out_valid}, 32'd0);
        check_val("abort_stop_ctrl", {30'd0, pdm_ctrl}, 32'd2);
        @(negedge clk);
        check_val("abort_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check_val("abort_no_done", 32'(n_done), 32'd0);
        run_seq(1, 2, 0, 0, 2, 1'b0);

        // Reset in the middle of WAIT_LO, then a zero-word two-frame run.
        clear_counts();
        ready_mode = 0; bsy_delay = 2; bsy_len = 10; bsy_never = 1'b0;
        pulse_start(1, 4);
        for (int k = 0; k < 100 && !pdm_bsy; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2; hreset_n = 1'b0; #1;
        check_reset_values("midreset");
        @(posedge clk); #1; hreset_n = 1'b1;
        repeat (15) @(negedge clk);
        run_seq(2, 0, 0, 1, 3, 1'b0);

        // Randomized runs.
        for (int t = 0; t < 8; t++)
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 12)),
                    int'($urandom_range(2, 6)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
